// File: rtl/pim_tile_if.sv
// pim_tile_if: job handshake and pim_unit control bundle for pim_tile_scheduler
// master: job_valid/abort/unit_done in; slave (scheduler): unit_start, tile row/col,
// commit_valid, job_ready/job_done/job_aborted, busy, err_spurious
interface pim_tile_if #(
  parameter int NUM_UNITS = 2,
  parameter int TW = 1
);
  logic job_valid, job_ready, abort, job_done, job_aborted, busy, err_spurious;
  logic [NUM_UNITS-1:0] unit_start, unit_done, commit_valid;
  logic [NUM_UNITS-1:0][TW-1:0] unit_tile_row, unit_tile_col;
  modport master (
    output job_valid, abort, unit_done,
    input job_ready, unit_start, unit_tile_row, unit_tile_col, commit_valid, job_done, job_aborted, busy, err_spurious
  );
  modport slave (
    input job_valid, abort, unit_done,
    output job_ready, unit_start, unit_tile_row, unit_tile_col, commit_valid, job_done, job_aborted, busy, err_spurious
  );
endinterface

// File: rtl/pim_tile_scheduler.sv
// pim_tile_scheduler: issues TILES_PER_DIM**2 tiles row-major onto a round-robin pool of pim_units
// ports: clk, rst (sync, active-high), bus (pim_tile_if.slave: job handshake, unit start/done, commits, status)
module pim_tile_scheduler #(
  parameter int NUM_UNITS = 2,
  parameter int TILES_PER_DIM = 2,
  parameter int TW = TILES_PER_DIM > 1 ? $clog2(TILES_PER_DIM) : 1,
  parameter int UW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1
) (
  input logic clk,
  input logic rst,
  pim_tile_if.slave bus
);
  localparam int NUM_TILES = TILES_PER_DIM * TILES_PER_DIM;
  localparam int CW = $clog2(NUM_TILES + 1);
  typedef enum logic [2:0] {IDLE, RUN, FINISH, DRAIN, ABORTED} state_t;
  state_t state_q, state_d;
  logic [NUM_UNITS-1:0] unit_busy_q, unit_busy_d, unit_start_q, unit_start_d, commit_q, commit_d, retire;
  logic [NUM_UNITS-1:0][TW-1:0] row_q, row_d, col_q, col_d;
  logic [UW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] issued_q, issued_d, done_cnt_q, done_cnt_d;
  logic job_done_q, job_done_d, job_aborted_q, job_aborted_d, err_q, err_d;
  logic found, dispatch;
  int tgt;
  // first free unit at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    tgt = 0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (!found && !unit_busy_q[(int'(rr_ptr_q) + i) % NUM_UNITS]) begin
        found = 1'b1;
        tgt = (int'(rr_ptr_q) + i) % NUM_UNITS;
      end
    end
  end
  always_comb begin
    retire = bus.unit_done & unit_busy_q;
    dispatch = state_q == RUN && !bus.abort && int'(issued_q) < NUM_TILES && found;
    state_d = state_q;
    unit_busy_d = unit_busy_q & ~retire;
    unit_start_d = '0;
    commit_d = retire;
    row_d = row_q;
    col_d = col_q;
    rr_ptr_d = rr_ptr_q;
    issued_d = issued_q;
    done_cnt_d = done_cnt_q + CW'($countones(retire));
    job_done_d = 1'b0;
    job_aborted_d = 1'b0;
    err_d = err_q | |(bus.unit_done & ~unit_busy_q);
    if (dispatch) begin
      unit_busy_d[tgt] = 1'b1;
      unit_start_d[tgt] = 1'b1;
      row_d[tgt] = TW'(issued_q / CW'(TILES_PER_DIM));
      col_d[tgt] = TW'(issued_q % CW'(TILES_PER_DIM));
      issued_d = issued_q + CW'(1);
      rr_ptr_d = UW'((tgt + 1) % NUM_UNITS);
    end
    case (state_q)
      IDLE: if (bus.job_valid) begin
        state_d = RUN;
        issued_d = '0;
        done_cnt_d = '0;
      end
      RUN: if (bus.abort) state_d = DRAIN;
        else if (int'(done_cnt_d) == NUM_TILES) begin
          state_d = FINISH;
          job_done_d = 1'b1;
        end
      DRAIN: if (unit_busy_q == '0) begin
        state_d = ABORTED;
        job_aborted_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      unit_busy_q <= '0;
      unit_start_q <= '0;
      commit_q <= '0;
      row_q <= '0;
      col_q <= '0;
      rr_ptr_q <= '0;
      issued_q <= '0;
      done_cnt_q <= '0;
      job_done_q <= 1'b0;
      job_aborted_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_busy_q <= unit_busy_d;
      unit_start_q <= unit_start_d;
      commit_q <= commit_d;
      row_q <= row_d;
      col_q <= col_d;
      rr_ptr_q <= rr_ptr_d;
      issued_q <= issued_d;
      done_cnt_q <= done_cnt_d;
      job_done_q <= job_done_d;
      job_aborted_q <= job_aborted_d;
      err_q <= err_d;
    end
  end
  assign bus.job_ready = state_q == IDLE;
  assign bus.busy = state_q != IDLE;
  assign bus.unit_start = unit_start_q;
  assign bus.unit_tile_row = row_q;
  assign bus.unit_tile_col = col_q;
  assign bus.commit_valid = commit_q;
  assign bus.job_done = job_done_q;
  assign bus.job_aborted = job_aborted_q;
  assign bus.err_spurious = err_q;
endmodule
